// File: rtl/scan_chain_ctrl.sv
// Scan-chain master: shifts din serially into one chain while collecting its previous contents into dout.
// Define SCAN_CAPTURE_EN to add a functional capture pulse (flop_clk) ahead of the shift.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] din,
`ifdef SCAN_CAPTURE_EN
    input  logic                 capture_req,
    output logic                 flop_clk,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] dout,
    output logic                 shift_en,
    output logic                 shift_clk,
    output logic                 scan_in,
    input  logic                 scan_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        HOLD     = 3'd4,
        DONE     = 3'd5
`ifdef SCAN_CAPTURE_EN
        , CAP_HI = 3'd6,
        CAP_LO   = 3'd7
`endif
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [CHAIN_LEN-1:0] tx_sr;
    logic [CHAIN_LEN-1:0] rx_sr;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CHAIN_LEN-1:0] tx_nxt;
    logic [CHAIN_LEN-1:0] rx_nxt;
    logic [CNT_W-1:0]     cnt_nxt;

    logic                 busy_d;
    logic                 done_d;
    logic                 shift_en_d;
    logic                 shift_clk_d;
    logic                 scan_in_d;
    logic [CHAIN_LEN-1:0] dout_d;
`ifdef SCAN_CAPTURE_EN
    logic                 flop_clk_d;
`endif

    // State and output registers; every chain-facing output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_en  <= 1'b0;
            shift_clk <= 1'b0;
            scan_in   <= 1'b0;
            dout      <= '0;
`ifdef SCAN_CAPTURE_EN
            flop_clk  <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            busy      <= busy_d;
            done      <= done_d;
            shift_en  <= shift_en_d;
            shift_clk <= shift_clk_d;
            scan_in   <= scan_in_d;
            dout      <= dout_d;
`ifdef SCAN_CAPTURE_EN
            flop_clk  <= flop_clk_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SCAN_CAPTURE_EN
                    next_state = capture_req ? CAP_HI : SETUP;
`else
                    next_state = SETUP;
`endif
                end
            end
            SETUP:    next_state = SHIFT_LO;
            SHIFT_LO: next_state = SHIFT_HI;
            SHIFT_HI: next_state = (bit_cnt == CNT_W'(CHAIN_LEN - 1)) ? HOLD : SHIFT_LO;
            HOLD:     next_state = DONE;
            DONE:     next_state = IDLE;
`ifdef SCAN_CAPTURE_EN
            CAP_HI:   next_state = CAP_LO;
            CAP_LO:   next_state = SETUP;
`endif
            default:  next_state = IDLE;
        endcase
    end

    // Shift datapath: chain tail sampled at the end of the low phase, tx advanced after the high phase.
    always_comb begin
        tx_nxt  = tx_sr;
        rx_nxt  = rx_sr;
        cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    tx_nxt  = din;
                    rx_nxt  = '0;
                    cnt_nxt = '0;
                end
            end
            SHIFT_LO: rx_nxt = {scan_out, rx_sr[CHAIN_LEN-1:1]};
            SHIFT_HI: begin
                tx_nxt  = {1'b0, tx_sr[CHAIN_LEN-1:1]};
                cnt_nxt = bit_cnt + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            tx_sr   <= tx_nxt;
            rx_sr   <= rx_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // Output decode from the state being entered so the registered outputs line up with it.
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        shift_en_d  = 1'b0;
        shift_clk_d = 1'b0;
        scan_in_d   = 1'b0;
        dout_d      = dout;
`ifdef SCAN_CAPTURE_EN
        flop_clk_d  = 1'b0;
`endif
        case (next_state)
            SETUP, SHIFT_LO: begin
                busy_d     = 1'b1;
                shift_en_d = 1'b1;
                scan_in_d  = tx_nxt[0];
            end
            SHIFT_HI: begin
                busy_d      = 1'b1;
                shift_en_d  = 1'b1;
                shift_clk_d = 1'b1;
                scan_in_d   = tx_nxt[0];
            end
            HOLD: begin
                busy_d     = 1'b1;
                shift_en_d = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
                dout_d = rx_nxt;
            end
`ifdef SCAN_CAPTURE_EN
            CAP_HI: begin
                busy_d     = 1'b1;
                flop_clk_d = 1'b1;
            end
            CAP_LO: busy_d = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl with a behavioural scan chain on the serial side.
// Define SCAN_CAPTURE_EN for both files to exercise the capture path.
module tb_scan_chain_ctrl;

    localparam int unsigned N       = 16;
    localparam int          LAT     = 2 * N + 3;
    localparam int          LAT_CAP = 2 * N + 5;

    typedef struct {
        logic [N-1:0] dout;
        logic [N-1:0] chain;
        int           acc;
        int           lat;
        bit           cap;
    } exp_t;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b1;
    logic         start       = 1'b0;
    logic [N-1:0] din         = '0;
    logic         capture_req = 1'b0;
    logic [N-1:0] func_in     = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] dout;
    logic         shift_en;
    logic         shift_clk;
    logic         scan_in;
    logic         scan_out;
    logic         flop_obs;

    logic [N-1:0] chain      = '0;
    logic         load_pulse = 1'b0;
    logic [N-1:0] load_val   = '0;

    int           cyc         = 0;
    int           next_ok     = 0;
    logic [N-1:0] ref_chain   = '0;
    exp_t         q[$];
    int           vectors     = 0;
    int           miscompares = 0;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .din         (din),
`ifdef SCAN_CAPTURE_EN
        .capture_req (capture_req),
        .flop_clk    (flop_obs),
`endif
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .shift_en    (shift_en),
        .shift_clk   (shift_clk),
        .scan_in     (scan_in),
        .scan_out    (scan_out)
    );

`ifndef SCAN_CAPTURE_EN
    assign flop_obs = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain word: bit 0 is the tail; each shift_clk rise pulls scan_in in at the head.
    assign scan_out = chain[0];
    always @(posedge shift_clk or posedge load_pulse or posedge flop_obs) begin
        if (load_pulse)
            chain <= load_val;
        else if (flop_obs && !shift_en)
            chain <= func_in;
        else if (shift_clk && shift_en)
            chain <= {scan_in, chain[N-1:1]};
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on done and polices chain-side protocol every cycle.
    always begin : mon
        exp_t         e;
        int           rises;
        int           pulses;
        logic         prev_sclk;
        logic         prev_sin;
        logic [N-1:0] last_dout;
        rises = 0; pulses = 0; prev_sclk = 1'b0; prev_sin = 1'b0; last_dout = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk("rst_busy", N'(busy), '0);
                chk("rst_done", N'(done), '0);
                chk("rst_shift_en", N'(shift_en), '0);
                chk("rst_shift_clk", N'(shift_clk), '0);
                chk("rst_scan_in", N'(scan_in), '0);
                chk("rst_flop_clk", N'(flop_obs), '0);
                chk("rst_dout", dout, '0);
                q.delete();
                rises = 0; pulses = 0; last_dout = '0;
            end else begin
                if (shift_clk && !prev_sclk) begin
                    rises++;
                    chk("shift_en_at_rise", N'(shift_en), N'(1));
                    chk("scan_in_stable", N'(scan_in), N'(prev_sin));
                end
                if (flop_obs) begin
                    pulses++;
                    chk("shift_en_at_capture", N'(shift_en), '0);
                end
                if (done) begin
                    if (q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_done at cycle %0d: got done=1, want none", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("dout", dout, e.dout);
                        chk("latency", N'(cyc - e.acc + 1), N'(e.lat));
                        chk("chain_after", chain, e.chain);
                        chk("rise_count", N'(rises), N'(N));
                        chk("capture_pulses", N'(pulses), N'(e.cap));
                        chk("busy_at_done", N'(busy), N'(1));
                        last_dout = e.dout;
                    end
                    rises = 0; pulses = 0;
                end else if (q.size() != 0 && (cyc - q[0].acc + 1) > q[0].lat + 2) begin
                    vectors++; miscompares++;
                    $display("FAIL done_timeout at cycle %0d: got no done, want one at latency %0d", cyc, q[0].lat);
                    void'(q.pop_front());
                    rises = 0; pulses = 0;
                end else if (q.size() == 0 && cyc + 1 >= next_ok) begin
                    chk("idle_busy", N'(busy), '0);
                    chk("idle_done", N'(done), '0);
                    chk("idle_shift_en", N'(shift_en), '0);
                    chk("idle_shift_clk", N'(shift_clk), '0);
                    chk("idle_scan_in", N'(scan_in), '0);
                    chk("idle_flop_clk", N'(flop_obs), '0);
                    chk("idle_dout_hold", dout, last_dout);
                end
            end
            prev_sclk = shift_clk;
            prev_sin  = scan_in;
        end
    end

    // One clock of stimulus; the reference decides whether the start just sampled is taken.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && start && cyc >= next_ok) begin
            e.cap   = capture_req;
            e.dout  = e.cap ? func_in : ref_chain;
            e.chain = din;
            e.acc   = cyc;
            e.lat   = e.cap ? LAT_CAP : LAT;
            q.push_back(e);
            ref_chain = din;
            next_ok   = cyc + e.lat + 1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && cyc + 1 >= next_ok) break;
            tick();
        end
    endtask

    task automatic preload(input logic [N-1:0] v);
        load_val   = v;
        load_pulse = 1'b1;
        #1;
        load_pulse = 1'b0;
        ref_chain  = v;
    endtask

    task automatic op(input logic [N-1:0] d, input bit cap);
        din         = d;
        capture_req = cap;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        capture_req = 1'b0;
    endtask

    initial begin : stim
        logic [N-1:0] pv;
        logic [N-1:0] dv;
        bit           cp;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        preload(16'hA5C3);
        op(16'h1234, 1'b0);
        wait_idle();

        // start held high across two operations; din changes while the first is busy
        din   = 16'hFFFF;
        start = 1'b1;
        tick();
        din = 16'h0000;
        repeat (2 * N + 4) tick();
        start = 1'b0;
        wait_idle();

        // reset during cycle 12 of a shift
        preload(N'($urandom));
        op(N'($urandom), 1'b0);
        repeat (11) tick();
        #1;
        rst_n   = 1'b0;
        next_ok = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        preload(N'($urandom));
        op(N'($urandom), 1'b0);
        wait_idle();

`ifdef SCAN_CAPTURE_EN
        preload(16'h3C3C);
        func_in = 16'h0F0F;
        op(16'h5A5A, 1'b1);
        wait_idle();
`endif

        for (int k = 0; k < 12; k++) begin
            pv = N'($urandom);
            dv = N'($urandom);
            cp = 1'b0;
`ifdef SCAN_CAPTURE_EN
            cp      = 1'($urandom_range(0, 1));
            func_in = N'($urandom);
`endif
            preload(pv);
            op(dv, cp);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) tick();
                din   = N'($urandom);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
        end

        wait_idle();
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
